uart_rx_config_set: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_os.sv | 137 +++++++++++++
 rtl/uart_rx_config_set.sv | 99 +++++++++
 tb/tb_uart_rx_config_set.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART config receive path.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 10_000_000;
  localparam int unsigned BAUD         = 115_200;
  // System clocks per UART bit, rounded to nearest (87 at 10 MHz / 115200).
  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_SET = 8'h53;  // 'S': next byte goes to busNow
  localparam logic [7:0] CMD_DEF = 8'h44;  // 'D': restore busNow from busDefault

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_BREAK = 3'd4
  } rx_state_e;

  typedef enum logic [0:0] {
    P_IDLE = 1'b0,
    P_VAL  = 1'b1
  } parse_state_e;

endpackage

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: two-flop input synchroniser plus oversampling receive FSM.
module uart_rx_os
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic             sync1_q, sync2_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign rx_s = sync2_q;

  // Synchronise the asynchronous serial pin; idle-high reset value avoids a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM state, counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: sample mid-bit, LSB first; leave the stop bit at its middle
  // so a back-to-back start edge is not missed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (!rx_s) begin
          state_d = R_START;
        end else begin
          state_d = R_IDLE;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = R_DATA;
          end else begin
            state_d = R_IDLE;  // too short to be a start bit
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = R_STOP;
          end else begin
            state_d = R_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = R_IDLE;
        end else begin
          state_d = R_BREAK;
        end
      end
      default: begin
        state_d = R_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_config_set.sv
// UART receiver plus command parser that drives the live config bus busNow.
module uart_rx_config_set
  import uart_pkg::*;
(
  input  logic       clk10mhz,
  input  logic       nRst,
  input  logic       uRx,
  input  logic [7:0] busDefault,
  output logic [7:0] busNow,
  output logic [7:0] rxData8,
  output logic       rxValid,
  output logic       frameErr,
  output logic       cfgUpd
);

  logic [7:0]   rx_data_s;
  logic         rx_valid_s;
  logic         frame_err_s;
  parse_state_e pstate_q, pstate_d;
  logic [7:0]   bus_q, bus_d;
  logic         upd_q, upd_d;
  logic         loaded_q, loaded_d;

  uart_rx_os u_rx (
    .clk       (clk10mhz),
    .rst_n     (nRst),
    .rx_in     (uRx),
    .rx_data   (rx_data_s),
    .rx_valid  (rx_valid_s),
    .frame_err (frame_err_s)
  );

  // Parser state, config bus, update strobe and post-reset load flag.
  always_ff @(posedge clk10mhz or negedge nRst) begin
    if (!nRst) begin
      pstate_q <= P_IDLE;
      bus_q    <= 8'h00;
      upd_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      bus_q    <= bus_d;
      upd_q    <= upd_d;
      loaded_q <= loaded_d;
    end
  end

  // Command parser: first cycle out of reset seeds busNow silently, then
  // 'S' arms a value load and 'D' restores the default.
  always_comb begin
    pstate_d = pstate_q;
    bus_d    = bus_q;
    upd_d    = 1'b0;
    loaded_d = loaded_q;
    if (!loaded_q) begin
      bus_d    = busDefault;
      loaded_d = 1'b1;
      pstate_d = P_IDLE;
    end else begin
      case (pstate_q)
        P_IDLE: begin
          if (rx_valid_s) begin
            if (rx_data_s == CMD_SET) begin
              pstate_d = P_VAL;
            end else if (rx_data_s == CMD_DEF) begin
              bus_d = busDefault;
              upd_d = 1'b1;
            end else begin
              pstate_d = P_IDLE;
            end
          end else begin
            pstate_d = P_IDLE;
          end
        end
        P_VAL: begin
          if (rx_valid_s) begin
            bus_d    = rx_data_s;
            upd_d    = 1'b1;
            pstate_d = P_IDLE;
          end else if (frame_err_s) begin
            pstate_d = P_IDLE;
          end else begin
            pstate_d = P_VAL;
          end
        end
        default: begin
          pstate_d = P_IDLE;
        end
      endcase
    end
  end

  assign busNow   = bus_q;
  assign cfgUpd   = upd_q;
  assign rxData8  = rx_data_s;
  assign rxValid  = rx_valid_s;
  assign frameErr = frame_err_s;

endmodule

// File: tb/tb_uart_rx_config_set.sv
// Scoreboard testbench for uart_rx_config_set: stimulus pushes expected
// receive events and config updates; a negedge monitor pops and compares.
module tb_uart_rx_config_set;

  localparam int BIT = 87;

  logic       clk10mhz = 1'b0;
  logic       nRst;
  logic       uRx;
  logic [7:0] busDefault;
  logic [7:0] busNow;
  logic [7:0] rxData8;
  logic       rxValid;
  logic       frameErr;
  logic       cfgUpd;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] bus_q[$];
  int total = 0;
  int bad   = 0;

  uart_rx_config_set dut (
    .clk10mhz   (clk10mhz),
    .nRst       (nRst),
    .uRx        (uRx),
    .busDefault (busDefault),
    .busNow     (busNow),
    .rxData8    (rxData8),
    .rxValid    (rxValid),
    .frameErr   (frameErr),
    .cfgUpd     (cfgUpd)
  );

  always #50 clk10mhz = ~clk10mhz;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clk10mhz) begin
    rx_exp_t e;
    if (nRst === 1'b1) begin
      if (rxValid && frameErr) fail_now("valid_and_ferr");
      if (rxValid || frameErr) begin
        if (rx_q.size() == 0) begin
          fail_now("rx_strobe_unexpected");
        end else begin
          e = rx_q.pop_front();
          chk("rx_kind_ferr", {7'd0, frameErr}, {7'd0, e.ferr});
          if (!e.ferr) chk("rx_data", rxData8, e.data);
        end
      end
      if (cfgUpd) begin
        if (bus_q.size() == 0) fail_now("cfg_upd_unexpected");
        else chk("bus_on_upd", busNow, bus_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk10mhz);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    uRx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      uRx = b[i];
      idle(BIT);
    end
    if (stop_low > 0) begin
      uRx = 1'b0;
      idle(BIT * stop_low);
    end
    uRx = 1'b1;
    idle(BIT);
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_exp_t e;
    e.ferr = 1'b0;
    e.data = d;
    rx_q.push_back(e);
  endtask

  task automatic push_ferr();
    rx_exp_t e;
    e.ferr = 1'b1;
    e.data = 8'h00;
    rx_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() == 0 && bus_q.size() == 0) break;
      @(negedge clk10mhz);
    end
    total++;
    if (rx_q.size() != 0 || bus_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d rx and %0d cfg events pending expected 0", name, rx_q.size(), bus_q.size());
      rx_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin
    nRst = 1'b0;
    uRx = 1'b1;
    busDefault = 8'hA5;
    idle(3);
    chk("rst_busNow", busNow, 8'h00);
    chk("rst_rxData8", rxData8, 8'h00);
    chk("rst_strobes", {5'd0, rxValid, frameErr, cfgUpd}, 8'h00);
    nRst = 1'b1;
    idle(1);
    chk("post_rst_load", busNow, 8'hA5);
    chk("post_rst_no_upd", {7'd0, cfgUpd}, 8'h00);
    idle(20);

    // 'S' then 3C
    push_rx(8'h53);
    send_byte(8'h53, 0);
    push_rx(8'h3C);
    bus_q.push_back(8'h3C);
    send_byte(8'h3C, 0);
    drain("set_3c");
    chk("busNow_3c", busNow, 8'h3C);

    // 'D' with new default, then a lone 00 is ignored
    busDefault = 8'h81;
    idle(5);
    chk("busNow_hold_def", busNow, 8'h3C);
    push_rx(8'h44);
    bus_q.push_back(8'h81);
    send_byte(8'h44, 0);
    push_rx(8'h00);
    send_byte(8'h00, 0);
    drain("def_81");
    chk("busNow_81", busNow, 8'h81);

    // 'S' then 77 with stop low for two bit times, then 12 ignored
    busDefault = 8'h5A;
    push_rx(8'h53);
    send_byte(8'h53, 0);
    push_ferr();
    send_byte(8'h77, 2);
    idle(BIT);
    chk("rxData_after_ferr", rxData8, 8'h53);
    push_rx(8'h12);
    send_byte(8'h12, 0);
    drain("ferr_seq");
    chk("busNow_after_ferr", busNow, 8'h81);

    // 20-clock glitch, then back-to-back 53 53
    uRx = 1'b0;
    idle(20);
    uRx = 1'b1;
    idle(100);
    drain("glitch");
    push_rx(8'h53);
    send_byte(8'h53, 0);
    push_rx(8'h53);
    bus_q.push_back(8'h53);
    send_byte(8'h53, 0);
    drain("b2b");
    chk("busNow_53", busNow, 8'h53);

    // Reset in the middle of the data bits of 'S'
    busDefault = 8'h81;
    uRx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 3; i++) begin
      uRx = (8'h53 >> i) & 8'h01;
      idle(BIT);
    end
    nRst = 1'b0;
    idle(1);
    chk("mid_rst_busNow", busNow, 8'h00);
    chk("mid_rst_rxData8", rxData8, 8'h00);
    chk("mid_rst_strobes", {5'd0, rxValid, frameErr, cfgUpd}, 8'h00);
    uRx = 1'b1;
    idle(5);
    nRst = 1'b1;
    idle(1);
    chk("mid_rst_reload", busNow, 8'h81);
    idle(10);
    push_rx(8'h53);
    send_byte(8'h53, 0);
    push_rx(8'h09);
    bus_q.push_back(8'h09);
    send_byte(8'h09, 0);
    drain("set_09");
    chk("busNow_09", busNow, 8'h09);
    chk("rxData_09", rxData8, 8'h09);

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
